vertical_counter: RTL and testbench

//  Downstream stage of the horizontal timing counter in the VGA display path.
//  - Consumes the per-line en_v_count pulse and hblank; produces line count, vsync, vblank, video_on and frame_start.
//  - Outputs feed the pixel generator and the matrix-result display logic.
//  - Default timing is VGA 640x480 @60Hz, vertical part: 480/10/2/33 lines, 525 total.

---
 rtl/vertical_counter_if.sv | 36 +++
 rtl/vertical_counter.sv | 97 +++++++++
 tb/tb_vertical_counter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vertical_counter_if.sv
// Signal bundle between the horizontal timing stage (master) and the vertical counter (slave).
// The frame_count signal exists only when VCNT_FRAME_COUNT_EN is defined.
interface vertical_counter_if;
  // Strobe semantics rather than a handshake: en_v_count is a one-cycle
  // qualifier sampled on every rising clk edge. The slave cannot stall it, and
  // each asserted cycle is consumed as exactly one line advance.
  logic        en_v_count;
  logic        hblank;
  logic [10:0] v_count;
  logic        vsync;
  logic        vblank;
  logic        video_on;
  logic        frame_start;
  logic [1:0]  v_state;
`ifdef VCNT_FRAME_COUNT_EN
  logic [15:0] frame_count;

  modport master (
    output en_v_count, hblank,
    input  v_count, vsync, vblank, video_on, frame_start, v_state, frame_count
  );
  modport slave (
    input  en_v_count, hblank,
    output v_count, vsync, vblank, video_on, frame_start, v_state, frame_count
  );
`else
  modport master (
    output en_v_count, hblank,
    input  v_count, vsync, vblank, video_on, frame_start, v_state
  );
  modport slave (
    input  en_v_count, hblank,
    output v_count, vsync, vblank, video_on, frame_start, v_state
  );
`endif
endinterface

// File: rtl/vertical_counter.sv
// VGA vertical timing counter: line count, vsync, vblank, video_on and frame_start.
// The optional 16-bit frame counter is built only when VCNT_FRAME_COUNT_EN is defined.
module vertical_counter #(
  parameter int V_VISIBLE_AREA = 480,
  parameter int V_FRONT_PORCH  = 10,
  parameter int V_SYNC_PULSE   = 2,
  parameter int V_BACK_PORCH   = 33
) (
  input  logic               clk,
  input  logic               reset,
  vertical_counter_if.slave  vif
);

  localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

  localparam logic [10:0] LAST_LINE   = 11'(V_TOTAL - 1);
  localparam logic [10:0] FRONT_START = 11'(V_VISIBLE_AREA);
  localparam logic [10:0] SYNC_START  = 11'(V_VISIBLE_AREA + V_FRONT_PORCH);
  localparam logic [10:0] BACK_START  = 11'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

  typedef enum logic [1:0] {
    V_ACTIVE = 2'd0,
    V_FRONT  = 2'd1,
    V_SYNC   = 2'd2,
    V_BACK   = 2'd3
  } v_state_t;

  v_state_t    state;
  v_state_t    next_state;
  logic [10:0] v_count;
  logic [10:0] next_count;
  logic        wrap;
  logic        vsync;
  logic        vblank;
  logic        video_on;
  logic        frame_start;

  // Any count at or beyond the last line (including unreachable out-of-range
  // values) advances to line 0; only the true last line counts as a frame wrap.
  always_comb begin
    wrap       = (v_count == LAST_LINE);
    next_count = (v_count >= LAST_LINE) ? 11'd0 : v_count + 11'd1;
    if (next_count < FRONT_START) begin
      next_state = V_ACTIVE;
    end else if (next_count < SYNC_START) begin
      next_state = V_FRONT;
    end else if (next_count < BACK_START) begin
      next_state = V_SYNC;
    end else begin
      next_state = V_BACK;
    end
  end

  // state, vsync and vblank all derive from the next line value so they move
  // on the same edge as v_count.
  always_ff @(posedge clk) begin
    if (reset) begin
      v_count     <= 11'd0;
      state       <= V_ACTIVE;
      vsync       <= 1'b1;
      vblank      <= 1'b0;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (vif.en_v_count) begin
        v_count <= next_count;
        state   <= next_state;
        vsync   <= (next_state != V_SYNC);
        vblank  <= (next_state != V_ACTIVE);
      end
      frame_start <= vif.en_v_count && wrap;
      video_on    <= !vif.hblank && !vblank;
    end
  end

`ifdef VCNT_FRAME_COUNT_EN
  logic [15:0] frame_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= 16'd0;
    end else if (vif.en_v_count && wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  assign vif.frame_count = frame_count;
`endif

  assign vif.v_count     = v_count;
  assign vif.vsync       = vsync;
  assign vif.vblank      = vblank;
  assign vif.video_on    = video_on;
  assign vif.frame_start = frame_start;
  assign vif.v_state     = state;

endmodule

// File: tb/tb_vertical_counter.sv
// Self-checking bench for vertical_counter: vector table plus multi-cycle frame sequences.
// Frame-counter checks are compiled in only with VCNT_FRAME_COUNT_EN.
module tb_vertical_counter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vertical_counter_if vif ();

  vertical_counter dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif.slave)
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int          mdl_v;
  int          n_checks;
  int          n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, advances the line model, and compares v_count.
  task automatic tick(input logic rst, input logic en, input logic hb);
    logic [10:0] e;
    reset          = rst;
    vif.en_v_count = en;
    vif.hblank     = hb;
    @(posedge clk);
    #1;
    if (rst) mdl_v = 0;
    else if (en) mdl_v = (mdl_v == 524) ? 0 : mdl_v + 1;
    exp_q.push_back(11'(mdl_v));
    e = exp_q.pop_front();
    chk("v_count_sb", 32'(vif.v_count), 32'(e));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        en;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic        vo;
    logic        fs;
  } vec_t;

  vec_t vecs[8];

  int vsync_low;
  int vblank_high;
  int fs_cnt;
  int vo_cnt;

  initial begin
    reset          = 1'b1;
    vif.en_v_count = 1'b0;
    vif.hblank     = 1'b0;
    mdl_v          = 0;
    n_checks       = 0;
    n_fail         = 0;

    //        rst   en    hb    v       vs    vb    vo    fs
    vecs[0] = '{1'b1, 1'b1, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 11'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 11'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 11'd1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 11'd2, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 11'd2, 1'b1, 1'b0, 1'b1, 1'b0};

    #2;
    for (int i = 0; i < 8; i++) begin
      tick(vecs[i].rst, vecs[i].en, vecs[i].hb);
      chk("vec_v_count",     32'(vif.v_count),     32'(vecs[i].v));
      chk("vec_vsync",       32'(vif.vsync),       32'(vecs[i].vs));
      chk("vec_vblank",      32'(vif.vblank),      32'(vecs[i].vb));
      chk("vec_video_on",    32'(vif.video_on),    32'(vecs[i].vo));
      chk("vec_frame_start", 32'(vif.frame_start), 32'(vecs[i].fs));
    end

    // video_on latency around line 10 and line 480
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
    chk("line10_v_count", 32'(vif.v_count), 32'd10);
    tick(1'b0, 1'b0, 1'b0);
    chk("line10_video_on_hb0", 32'(vif.video_on), 32'd1);
    tick(1'b0, 1'b0, 1'b1);
    chk("line10_video_on_hb1", 32'(vif.video_on), 32'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("line10_video_on_back", 32'(vif.video_on), 32'd1);
    for (int i = 0; i < 470; i++) tick(1'b0, 1'b1, 1'b0);
    chk("line480_v_count", 32'(vif.v_count), 32'd480);
    chk("line480_vblank", 32'(vif.vblank), 32'd1);
    chk("line480_video_on_lag", 32'(vif.video_on), 32'd1);
    chk("line480_state", 32'(vif.v_state), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    chk("line480_video_on_off", 32'(vif.video_on), 32'd0);

    // reset while in vsync
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 491; i++) tick(1'b0, 1'b1, 1'b0);
    chk("sync491_v_count", 32'(vif.v_count), 32'd491);
    chk("sync491_vsync", 32'(vif.vsync), 32'd0);
    chk("sync491_state", 32'(vif.v_state), 32'd2);
    tick(1'b1, 1'b1, 1'b0);
    chk("rst_mid_v_count", 32'(vif.v_count), 32'd0);
    chk("rst_mid_vsync", 32'(vif.vsync), 32'd1);
    chk("rst_mid_vblank", 32'(vif.vblank), 32'd0);
    chk("rst_mid_state", 32'(vif.v_state), 32'd0);
    chk("rst_mid_frame_start", 32'(vif.frame_start), 32'd0);
`ifdef VCNT_FRAME_COUNT_EN
    chk("rst_mid_frame_count", 32'(vif.frame_count), 32'd0);
`endif

    // full frame with one line every 4 cycles: 2100 cycles
    vsync_low   = 0;
    vblank_high = 0;
    fs_cnt      = 0;
    vo_cnt      = 0;
    for (int k = 1; k <= 2100; k++) begin
      tick(1'b0, (k % 4) == 0, 1'b0);
      if (!vif.vsync)      vsync_low++;
      if (vif.vblank)      vblank_high++;
      if (vif.frame_start) fs_cnt++;
      if (vif.video_on)    vo_cnt++;
    end
    chk("frame_vsync_low_cycles", 32'(vsync_low), 32'd8);
    chk("frame_vblank_cycles", 32'(vblank_high), 32'd180);
    chk("frame_start_pulses", 32'(fs_cnt), 32'd1);
    chk("frame_video_on_cycles", 32'(vo_cnt), 32'd1920);
    chk("frame_end_v_count", 32'(vif.v_count), 32'd0);
    chk("frame_end_frame_start", 32'(vif.frame_start), 32'd1);
`ifdef VCNT_FRAME_COUNT_EN
    chk("frame_count_after_1", 32'(vif.frame_count), 32'd1);
`endif

    // continuous en_v_count for 600 cycles
    fs_cnt = 0;
    for (int i = 1; i <= 600; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      if (vif.frame_start) begin
        fs_cnt++;
        chk("cont_frame_start_cycle", 32'(i), 32'd525);
      end
    end
    chk("cont_frame_start_pulses", 32'(fs_cnt), 32'd1);
    chk("cont_end_v_count", 32'(vif.v_count), 32'd75);
`ifdef VCNT_FRAME_COUNT_EN
    chk("frame_count_after_2", 32'(vif.frame_count), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
